// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-control bundle between the pipeline datapath and the hazard controller.
// master = datapath side (supplies decode/execute fields, consumes enables);
// slave  = hazard controller.
interface pipeline_hazard_ctrl_if;
   logic [4:0] rs1_D;
   logic [4:0] rs2_D;
   logic [4:0] rd_E;
   logic       mem_read_E;
   logic       branch_taken_E;
   logic       mem_busy;
   logic       pc_en;
   logic       ir1_en;
   logic       ir2_en;
   logic       ir3_en;
   logic       ir1_flush;
   logic       ir2_flush;

   modport master (
      output rs1_D, rs2_D, rd_E, mem_read_E, branch_taken_E, mem_busy,
      input  pc_en, ir1_en, ir2_en, ir3_en, ir1_flush, ir2_flush
   );

   modport slave (
      input  rs1_D, rs2_D, rd_E, mem_read_E, branch_taken_E, mem_busy,
      output pc_en, ir1_en, ir2_en, ir3_en, ir1_flush, ir2_flush
   );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, taken-branch flushes, memory-busy
// freeze, saturating event counters and a sticky memory-busy timeout flag.
module pipeline_hazard_ctrl #(
   parameter int unsigned FLUSH_CYCLES = 2,
   parameter int unsigned TIMEOUT      = 255,
   parameter int unsigned CNT_W        = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   pipeline_hazard_ctrl_if.slave hz,
   input  logic                 clr_cnt,
   output logic [1:0]           state_o,
   output logic [CNT_W-1:0]     stall_cnt,
   output logic [CNT_W-1:0]     flush_cnt,
   output logic                 timeout_err
);

   typedef enum logic [1:0] {StRun = 2'd0, StFlush = 2'd1} state_t;

   localparam logic [3:0]       FlushInit = 4'(FLUSH_CYCLES - 1);
   localparam logic [16:0]      TimeoutV  = 17'(TIMEOUT);
   localparam logic [16:0]      BusyMax   = '1;
   localparam logic [CNT_W-1:0] CntMax    = '1;

   state_t           state_q, state_d;
   logic [3:0]       dcnt_q, dcnt_d;
   logic [CNT_W-1:0] stall_q, stall_d;
   logic [CNT_W-1:0] flush_q, flush_d;
   logic [16:0]      busy_q, busy_d;
   logic             err_q, err_d;

   logic load_use;
   logic flush_evt;
   logic pc_en, ir1_en, ir2_en, ir3_en, ir1_flush, ir2_flush;

   // Next state and combinational enables/flushes by priority: busy > branch > load-use.
   always_comb begin
      state_d   = state_q;
      dcnt_d    = dcnt_q;
      flush_evt = 1'b0;
      pc_en     = 1'b1;
      ir1_en    = 1'b1;
      ir2_en    = 1'b1;
      ir3_en    = 1'b1;
      ir1_flush = 1'b0;
      ir2_flush = 1'b0;
      load_use  = hz.mem_read_E && (hz.rd_E != 5'd0) &&
                  ((hz.rd_E == hz.rs1_D) || (hz.rd_E == hz.rs2_D));
      if (hz.mem_busy) begin
         pc_en  = 1'b0;
         ir1_en = 1'b0;
         ir2_en = 1'b0;
         ir3_en = 1'b0;
      end else begin
         unique case (state_q)
            StRun: begin
               if (hz.branch_taken_E) begin
                  ir1_flush = 1'b1;
                  ir2_flush = 1'b1;
                  flush_evt = 1'b1;
                  if (FLUSH_CYCLES > 1) begin
                     state_d = StFlush;
                     dcnt_d  = FlushInit;
                  end
               end else if (load_use) begin
                  pc_en     = 1'b0;
                  ir1_en    = 1'b0;
                  ir2_flush = 1'b1;
               end
            end
            StFlush: begin
               // Branch and load-use are ignored while bubbles drain.
               ir1_flush = 1'b1;
               dcnt_d    = dcnt_q - 4'd1;
               if (dcnt_q <= 4'd1) begin
                  state_d = StRun;
                  dcnt_d  = 4'd0;
               end
            end
            default: begin
               state_d = StRun;
               dcnt_d  = 4'd0;
            end
         endcase
      end
      // Hold reset-time outputs at the RUN no-event values regardless of inputs.
      if (!rst) begin
         pc_en     = 1'b1;
         ir1_en    = 1'b1;
         ir2_en    = 1'b1;
         ir3_en    = 1'b1;
         ir1_flush = 1'b0;
         ir2_flush = 1'b0;
      end
   end

   // Counter and timeout-flag next values; clear wins over any increment.
   always_comb begin
      stall_d = stall_q;
      flush_d = flush_q;
      busy_d  = 17'd0;
      err_d   = err_q;
      if (!pc_en && (stall_q != CntMax)) stall_d = stall_q + 1'b1;
      if (flush_evt && (flush_q != CntMax)) flush_d = flush_q + 1'b1;
      if (hz.mem_busy) begin
         busy_d = (busy_q == BusyMax) ? busy_q : busy_q + 17'd1;
         if (busy_d > TimeoutV) err_d = 1'b1;
      end
      if (clr_cnt) begin
         stall_d = '0;
         flush_d = '0;
         err_d   = 1'b0;
      end
   end

   // State, flush down-counter, event counters and timeout flag registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= StRun;
         dcnt_q  <= 4'd0;
         stall_q <= '0;
         flush_q <= '0;
         busy_q  <= 17'd0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         dcnt_q  <= dcnt_d;
         stall_q <= stall_d;
         flush_q <= flush_d;
         busy_q  <= busy_d;
         err_q   <= err_d;
      end
   end

   assign hz.pc_en     = pc_en;
   assign hz.ir1_en    = ir1_en;
   assign hz.ir2_en    = ir2_en;
   assign hz.ir3_en    = ir3_en;
   assign hz.ir1_flush = ir1_flush;
   assign hz.ir2_flush = ir2_flush;
   assign state_o      = state_q;
   assign stall_cnt    = stall_q;
   assign flush_cnt    = flush_q;
   assign timeout_err  = err_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed + random bench for pipeline_hazard_ctrl with a spec-level reference
// model feeding an expected-output queue.
module tb_pipeline_hazard_ctrl;

   localparam int unsigned FC   = 2;
   localparam int unsigned TO   = 4;
   localparam int unsigned CW   = 4;
   localparam int          CMAX = (1 << CW) - 1;

   typedef struct {
      logic pc_en, ir1_en, ir2_en, ir3_en, ir1_flush, ir2_flush;
      int   state, stall, flush;
      logic err;
   } exp_t;

   logic          clk;
   logic          rst;
   logic          clr_cnt;
   logic [1:0]    state_o;
   logic [CW-1:0] stall_cnt, flush_cnt;
   logic          timeout_err;

   pipeline_hazard_ctrl_if hz ();

   pipeline_hazard_ctrl #(
      .FLUSH_CYCLES (FC),
      .TIMEOUT      (TO),
      .CNT_W        (CW)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .hz          (hz),
      .clr_cnt     (clr_cnt),
      .state_o     (state_o),
      .stall_cnt   (stall_cnt),
      .flush_cnt   (flush_cnt),
      .timeout_err (timeout_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int   n_pass = 0;
   int   n_total = 0;
   exp_t sb[$];

   // Reference model state
   int m_state, m_dcnt, m_stall, m_flush, m_busy;
   logic m_err;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
   endtask

   task automatic model_reset();
      m_state = 0; m_dcnt = 0; m_stall = 0; m_flush = 0; m_busy = 0; m_err = 1'b0;
   endtask

   task automatic compare(input exp_t e);
      check("pc_en",       32'(hz.pc_en),     32'(e.pc_en));
      check("ir1_en",      32'(hz.ir1_en),    32'(e.ir1_en));
      check("ir2_en",      32'(hz.ir2_en),    32'(e.ir2_en));
      check("ir3_en",      32'(hz.ir3_en),    32'(e.ir3_en));
      check("ir1_flush",   32'(hz.ir1_flush), 32'(e.ir1_flush));
      check("ir2_flush",   32'(hz.ir2_flush), 32'(e.ir2_flush));
      check("state_o",     32'(state_o),      32'(e.state));
      check("stall_cnt",   32'(stall_cnt),    32'(e.stall));
      check("flush_cnt",   32'(flush_cnt),    32'(e.flush));
      check("timeout_err", 32'(timeout_err),  32'(e.err));
   endtask

   // One clock cycle: drive, predict, compare before the edge, advance model.
   task automatic step(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                       input logic mr, input logic bt, input logic mb, input logic clr);
      exp_t e;
      logic lu;
      hz.rs1_D = rs1; hz.rs2_D = rs2; hz.rd_E = rd;
      hz.mem_read_E = mr; hz.branch_taken_E = bt; hz.mem_busy = mb; clr_cnt = clr;
      lu = mr && (rd != 5'd0) && ((rd == rs1) || (rd == rs2));
      e.pc_en = 1; e.ir1_en = 1; e.ir2_en = 1; e.ir3_en = 1;
      e.ir1_flush = 0; e.ir2_flush = 0;
      if (mb) begin
         e.pc_en = 0; e.ir1_en = 0; e.ir2_en = 0; e.ir3_en = 0;
      end else if (m_state == 1) begin
         e.ir1_flush = 1;
      end else if (bt) begin
         e.ir1_flush = 1; e.ir2_flush = 1;
      end else if (lu) begin
         e.pc_en = 0; e.ir1_en = 0; e.ir2_flush = 1;
      end
      e.state = m_state; e.stall = m_stall; e.flush = m_flush; e.err = m_err;
      sb.push_back(e);
      #2;
      compare(sb.pop_front());
      // model update at the coming edge
      if (clr) m_stall = 0;
      else if (!e.pc_en && m_stall < CMAX) m_stall++;
      if (clr) m_flush = 0;
      else if (!mb && m_state == 0 && bt && m_flush < CMAX) m_flush++;
      if (mb) m_busy++; else m_busy = 0;
      if (clr) m_err = 1'b0;
      else if (mb && m_busy > int'(TO)) m_err = 1'b1;
      if (!mb) begin
         if (m_state == 0 && bt) begin
            if (FC > 1) begin m_state = 1; m_dcnt = FC - 1; end
         end else if (m_state == 1) begin
            m_dcnt--;
            if (m_dcnt == 0) m_state = 0;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      step(5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset with mem_busy asserted: outputs must still show RUN no-event values.
      rst = 1'b0; clr_cnt = 1'b0;
      hz.rs1_D = 5'd5; hz.rs2_D = 5'd0; hz.rd_E = 5'd5;
      hz.mem_read_E = 1'b1; hz.branch_taken_E = 1'b1; hz.mem_busy = 1'b1;
      model_reset();
      #3;
      check("rst_pc_en", 32'(hz.pc_en), 32'd1);
      check("rst_ir1_en", 32'(hz.ir1_en), 32'd1);
      check("rst_ir1_flush", 32'(hz.ir1_flush), 32'd0);
      check("rst_ir2_flush", 32'(hz.ir2_flush), 32'd0);
      check("rst_state", 32'(state_o), 32'd0);
      check("rst_stall", 32'(stall_cnt), 32'd0);
      check("rst_err", 32'(timeout_err), 32'd0);
      hz.mem_busy = 1'b0; hz.branch_taken_E = 1'b0; hz.mem_read_E = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;

      idle();
      // Load-use on rs1, then on rs2, then rd=0 (no stall)
      step(5'd5, 5'd9, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
      idle();
      step(5'd7, 5'd12, 5'd12, 1'b1, 1'b0, 1'b0, 1'b0);
      step(5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
      step(5'd5, 5'd9, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0);
      idle();
      // Taken branch, FLUSH bubble, back to RUN
      step(5'd1, 5'd2, 5'd3, 1'b0, 1'b1, 1'b0, 1'b0);
      step(5'd3, 5'd2, 5'd3, 1'b1, 1'b1, 1'b0, 1'b0);
      idle();
      // Branch, then mem_busy 3 cycles during FLUSH
      step(5'd1, 5'd2, 5'd3, 1'b0, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) step(5'd1, 5'd2, 5'd3, 1'b0, 1'b1, 1'b1, 1'b0);
      idle();
      idle();
      // Branch and load-use together
      step(5'd4, 5'd2, 5'd4, 1'b1, 1'b1, 1'b0, 1'b0);
      idle();
      idle();
      // Five busy cycles trip the timeout, then clear
      for (int i = 0; i < 5; i++) idle_busy();
      idle();
      step(5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b0, 1'b1);
      idle();
      // Clear coinciding with a stall
      step(5'd6, 5'd2, 5'd6, 1'b1, 1'b0, 1'b0, 1'b1);
      idle();
      // Stall counter saturation
      for (int i = 0; i < 20; i++) step(5'd6, 5'd2, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0);
      idle();
      // Random traffic
      for (int i = 0; i < 60; i++) begin
         step(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 5) == 0),
              1'($urandom_range(0, 6) == 0), 1'($urandom_range(0, 19) == 0));
      end
      idle();
      idle();
      // Reset asserted mid-FLUSH
      step(5'd1, 5'd2, 5'd3, 1'b0, 1'b1, 1'b0, 1'b0);
      hz.branch_taken_E = 1'b0;
      #3;
      rst = 1'b0;
      #1;
      check("midrst_state", 32'(state_o), 32'd0);
      check("midrst_ir1_flush", 32'(hz.ir1_flush), 32'd0);
      check("midrst_flush_cnt", 32'(flush_cnt), 32'd0);
      model_reset();
      @(posedge clk); #1;
      rst = 1'b1;
      idle();
      idle();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   task automatic idle_busy();
      step(5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b1, 1'b0);
   endtask

endmodule
